// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller:
// FSM state encoding, datapath widths and the per-step shift table.
package mult_pkg;

  localparam int NIB_W  = 4;
  localparam int OP_W   = 2 * NIB_W;
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Left shift applied to the core output at each partial-product step:
  // lo*lo -> 0, hi*lo -> 4, lo*hi -> 4, hi*hi -> 8.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    sh = 4'd0;
    case (step)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'(NIB_W);
      2'd2:    sh = 4'(NIB_W);
      default: sh = 4'(2 * NIB_W);
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mult4x4_core.sv
// Purely combinational NIB_W x NIB_W unsigned array multiplier:
// an AND array of partial products reduced by ripple full-adder rows.
module mult4x4_core
  import mult_pkg::*;
(
  input  logic [NIB_W-1:0]   a_i,
  input  logic [NIB_W-1:0]   b_i,
  output logic [2*NIB_W-1:0] p_o
);

  // Row i adds (a & b[i]) onto the upper bits of the running sum; the
  // lowest bit of each row is final and drops out as product bit i.
  always_comb begin
    logic [NIB_W:0] row;
    logic [NIB_W:0] nxt;
    logic           c;
    logic           pp;
    p_o    = '0;
    nxt    = '0;
    c      = 1'b0;
    pp     = 1'b0;
    row    = {1'b0, a_i & {NIB_W{b_i[0]}}};
    p_o[0] = row[0];
    for (int i = 1; i < NIB_W; i++) begin
      c   = 1'b0;
      nxt = '0;
      for (int j = 0; j < NIB_W; j++) begin
        pp     = a_i[j] & b_i[i];
        nxt[j] = row[j+1] ^ pp ^ c;
        c      = (row[j+1] & pp) | (row[j+1] & c) | (pp & c);
      end
      nxt[NIB_W] = c;
      p_o[i]     = nxt[0];
      row        = nxt;
    end
    p_o[2*NIB_W-1:NIB_W] = row[NIB_W:1];
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller: 8x8 unsigned product from one shared 4x4 core,
// four nibble steps accumulated into a 16-bit register.
// Handshakes: a transfer happens on a rising clk edge where valid & ready
// are both high; valid/data hold until that edge; ready may depend on the
// consumer's ready combinationally (in_ready follows out_ready in DONE).
// Optional build macro: MULT_SKIP_ZERO_EN -- a zero operand at acceptance
// bypasses MUL and presents 0 on the next cycle.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int STEPS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic              busy,
  output state_e            dbg_state_o
);

  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  state_e            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;

  logic              accept;
  logic              skip_zero;
  logic [NIB_W-1:0]  sel_a;
  logic [NIB_W-1:0]  sel_b;
  logic [OP_W-1:0]   core_p;
  logic [PROD_W-1:0] partial;

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

`ifdef MULT_SKIP_ZERO_EN
  assign skip_zero = (in_a == '0) | (in_b == '0);
`else
  assign skip_zero = 1'b0;
`endif

  // step bit 0 picks the multiplicand nibble, bit 1 the multiplier nibble
  assign sel_a = step_q[0] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
  assign sel_b = step_q[1] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];

  mult4x4_core u_core (
    .a_i (sel_a),
    .b_i (sel_b),
    .p_o (core_p)
  );

  assign partial = PROD_W'(core_p) << step_shift(step_q);

  assign out_valid   = (state_q == DONE);
  assign out_p       = out_valid ? acc_q : '0;
  assign busy        = (state_q == MUL);
  assign dbg_state_o = state_q;

  // Next state: step through MUL, retire in DONE, and let an accept
  // override everything so DONE->MUL needs no idle bubble.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      MUL: begin
        acc_d  = acc_q + partial;
        step_d = step_q + 2'd1;
        if (step_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      IDLE: ;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      a_d     = in_a;
      b_d     = in_b;
      acc_d   = '0;
      step_d  = '0;
      state_d = skip_zero ? DONE : MUL;
    end
  end

  // State, step counter, operands and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // The step counter must never run past the last partial product
  always_ff @(posedge clk) begin
    if (rst_n && state_q == MUL) assert (int'(step_q) < STEPS);
  end

endmodule
